// File: rtl/pms_mem_issue.sv
// Pre-memory stage: latches an instruction pair, flags AdEL/AdES and issues up to two
// data-SRAM requests (slot 1 first). Optional stall counter under PMS_STALL_CNT_EN.
module pms_mem_issue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_all,
  input  logic              es_to_pms_valid,
  output logic              pms_allowin,
  input  logic              inst1_valid,
  input  logic              inst1_mem_re,
  input  logic              inst1_mem_we,
  input  logic [1:0]        inst1_size,
  input  logic [ADDR_W-1:0] inst1_addr,
  input  logic [DATA_W-1:0] inst1_wdata,
  input  logic              inst1_except_in,
  input  logic              inst2_valid,
  input  logic              inst2_mem_re,
  input  logic              inst2_mem_we,
  input  logic [1:0]        inst2_size,
  input  logic [ADDR_W-1:0] inst2_addr,
  input  logic [DATA_W-1:0] inst2_wdata,
  input  logic              inst2_except_in,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              ms_allowin,
  output logic              pms_to_ms_valid,
  output logic              inst1_ale,
  output logic [4:0]        inst1_exccode,
  output logic [ADDR_W-1:0] inst1_badvaddr,
  output logic              inst1_req_sent,
  output logic              inst2_ale,
  output logic [4:0]        inst2_exccode,
  output logic [ADDR_W-1:0] inst2_badvaddr,
  output logic              inst2_req_sent
`ifdef PMS_STALL_CNT_EN
  , output logic [31:0]     pms_stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, REQ1, REQ2, DONE, DRAIN} state_e;

  typedef struct packed {
    logic              valid;
    logic              re;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              exc;
  } slot_t;

  function automatic logic ale_f(input slot_t s);
    logic mis;
    case (s.size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = s.addr[0];
      default: mis = (s.addr[1:0] != 2'b00);
    endcase
    return s.valid & (s.re | s.we) & mis;
  endfunction

  function automatic logic need1_f(input slot_t s1);
    return s1.valid & (s1.re | s1.we) & !s1.exc & !ale_f(s1);
  endfunction

  // A faulting slot 1 suppresses slot 2's request so exceptions stay precise.
  function automatic logic need2_f(input slot_t s1, input slot_t s2);
    return s2.valid & (s2.re | s2.we) & !s2.exc & !ale_f(s2) & !(s1.exc | ale_f(s1));
  endfunction

  function automatic logic [3:0] wstrb_f(input logic we, input logic [1:0] size, input logic [1:0] lo);
    if (!we) return 4'b0000;
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] wdata_f(input logic [1:0] size, input logic [DATA_W-1:0] w);
    case (size)
      2'd0:    return DATA_W'({4{w[7:0]}});
      2'd1:    return DATA_W'({2{w[15:0]}});
      default: return w;
    endcase
  endfunction

  state_e state_q, state_d;
  slot_t  s1_q, s2_q, in1_s, in2_s;
  logic   pms_valid_q, pms_valid_d;
  logic   sent1_q, sent1_d, sent2_q, sent2_d;
  logic   drain2_q, drain2_d;
  logic   ready_go, handoff, latch, need2_q;
  state_e target_in;

  assign in1_s = '{inst1_valid, inst1_mem_re, inst1_mem_we, inst1_size, inst1_addr, inst1_wdata, inst1_except_in};
  assign in2_s = '{inst2_valid, inst2_mem_re, inst2_mem_we, inst2_size, inst2_addr, inst2_wdata, inst2_except_in};

  assign ready_go        = (state_q == DONE);
  assign pms_allowin     = (state_q != DRAIN) & (!pms_valid_q | (ready_go & ms_allowin));
  assign latch           = es_to_pms_valid & pms_allowin & !clear_all;
  assign handoff         = pms_valid_q & ready_go & ms_allowin;
  assign pms_to_ms_valid = pms_valid_q & ready_go;
  assign need2_q         = need2_f(s1_q, s2_q);
  assign target_in       = need1_f(in1_s) ? REQ1 : (need2_f(in1_s, in2_s) ? REQ2 : DONE);

  always_comb begin
    state_d     = state_q;
    pms_valid_d = pms_valid_q;
    sent1_d     = sent1_q;
    sent2_d     = sent2_q;
    drain2_d    = drain2_q;
    if (clear_all)    pms_valid_d = 1'b0;
    else if (latch)   pms_valid_d = 1'b1;
    else if (handoff) pms_valid_d = 1'b0;
    else              pms_valid_d = pms_valid_q;
    if (latch) begin
      sent1_d = 1'b0;
      sent2_d = 1'b0;
    end else begin
      sent1_d = sent1_q;
    end
    case (state_q)
      IDLE:  state_d = latch ? target_in : IDLE;
      REQ1: begin
        if (clear_all) begin
          state_d  = data_sram_addr_ok ? IDLE : DRAIN;
          drain2_d = 1'b0;
        end else if (data_sram_addr_ok) begin
          sent1_d = 1'b1;
          state_d = need2_q ? REQ2 : DONE;
        end else begin
          state_d = REQ1;
        end
      end
      REQ2: begin
        if (clear_all) begin
          state_d  = data_sram_addr_ok ? IDLE : DRAIN;
          drain2_d = 1'b1;
        end else if (data_sram_addr_ok) begin
          sent2_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = REQ2;
        end
      end
      DONE: begin
        if (clear_all)    state_d = IDLE;
        else if (handoff) state_d = latch ? target_in : IDLE;
        else              state_d = DONE;
      end
      // The flushed request must still complete its handshake before the bus is released.
      DRAIN:   state_d = data_sram_addr_ok ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pms_valid_q <= 1'b0;
      sent1_q     <= 1'b0;
      sent2_q     <= 1'b0;
      drain2_q    <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
    end else begin
      state_q     <= state_d;
      pms_valid_q <= pms_valid_d;
      sent1_q     <= sent1_d;
      sent2_q     <= sent2_d;
      drain2_q    <= drain2_d;
      if (latch) begin
        s1_q <= in1_s;
        s2_q <= in2_s;
      end
    end
  end

  logic use2;
  assign use2            = (state_q == REQ2) | ((state_q == DRAIN) & drain2_q);
  assign data_sram_req   = (state_q == REQ1) | (state_q == REQ2) | (state_q == DRAIN);
  assign data_sram_wr    = use2 ? s2_q.we : s1_q.we;
  assign data_sram_size  = use2 ? s2_q.size : s1_q.size;
  assign data_sram_addr  = use2 ? s2_q.addr : s1_q.addr;
  assign data_sram_wstrb = use2 ? wstrb_f(s2_q.we, s2_q.size, s2_q.addr[1:0])
                                : wstrb_f(s1_q.we, s1_q.size, s1_q.addr[1:0]);
  assign data_sram_wdata = use2 ? wdata_f(s2_q.size, s2_q.wdata) : wdata_f(s1_q.size, s1_q.wdata);

  assign inst1_ale      = pms_valid_q & ale_f(s1_q);
  assign inst2_ale      = pms_valid_q & ale_f(s2_q);
  assign inst1_exccode  = inst1_ale ? (s1_q.we ? 5'h05 : 5'h04) : 5'h00;
  assign inst2_exccode  = inst2_ale ? (s2_q.we ? 5'h05 : 5'h04) : 5'h00;
  assign inst1_badvaddr = inst1_ale ? s1_q.addr : '0;
  assign inst2_badvaddr = inst2_ale ? s2_q.addr : '0;
  assign inst1_req_sent = sent1_q;
  assign inst2_req_sent = sent2_q;

`ifdef PMS_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset)                                       stall_cnt_q <= 32'd0;
    else if (data_sram_req & !data_sram_addr_ok)     stall_cnt_q <= stall_cnt_q + 32'd1;
    else                                             stall_cnt_q <= stall_cnt_q;
  end
  assign pms_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pms_mem_issue.sv
// Directed and randomized checks of pms_mem_issue against a transaction-level model.
module tb_pms_mem_issue;
  logic        clk = 1'b0;
  logic        reset, clear_all, es_to_pms_valid, pms_allowin;
  logic        inst1_valid, inst1_mem_re, inst1_mem_we, inst1_except_in;
  logic        inst2_valid, inst2_mem_re, inst2_mem_we, inst2_except_in;
  logic [1:0]  inst1_size, inst2_size, data_sram_size;
  logic [31:0] inst1_addr, inst1_wdata, inst2_addr, inst2_wdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, ms_allowin, pms_to_ms_valid;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        inst1_ale, inst2_ale, inst1_req_sent, inst2_req_sent;
  logic [4:0]  inst1_exccode, inst2_exccode;
  logic [31:0] inst1_badvaddr, inst2_badvaddr;
`ifdef PMS_STALL_CNT_EN
  logic [31:0] pms_stall_cnt;
`endif

  pms_mem_issue dut (
    .clk(clk), .reset(reset), .clear_all(clear_all), .es_to_pms_valid(es_to_pms_valid),
    .pms_allowin(pms_allowin),
    .inst1_valid(inst1_valid), .inst1_mem_re(inst1_mem_re), .inst1_mem_we(inst1_mem_we),
    .inst1_size(inst1_size), .inst1_addr(inst1_addr), .inst1_wdata(inst1_wdata),
    .inst1_except_in(inst1_except_in),
    .inst2_valid(inst2_valid), .inst2_mem_re(inst2_mem_re), .inst2_mem_we(inst2_mem_we),
    .inst2_size(inst2_size), .inst2_addr(inst2_addr), .inst2_wdata(inst2_wdata),
    .inst2_except_in(inst2_except_in),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .ms_allowin(ms_allowin), .pms_to_ms_valid(pms_to_ms_valid),
    .inst1_ale(inst1_ale), .inst1_exccode(inst1_exccode), .inst1_badvaddr(inst1_badvaddr),
    .inst1_req_sent(inst1_req_sent),
    .inst2_ale(inst2_ale), .inst2_exccode(inst2_exccode), .inst2_badvaddr(inst2_badvaddr),
    .inst2_req_sent(inst2_req_sent)
`ifdef PMS_STALL_CNT_EN
    , .pms_stall_cnt(pms_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int chk_total = 0;
  int chk_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_total++;
    assert (obs === exp) chk_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic v, re, we, input logic [1:0] sz, input logic [31:0] a, w, input logic e);
    inst1_valid = v; inst1_mem_re = re; inst1_mem_we = we; inst1_size = sz;
    inst1_addr = a; inst1_wdata = w; inst1_except_in = e;
  endtask

  task automatic set2(input logic v, re, we, input logic [1:0] sz, input logic [31:0] a, w, input logic e);
    inst2_valid = v; inst2_mem_re = re; inst2_mem_we = we; inst2_size = sz;
    inst2_addr = a; inst2_wdata = w; inst2_except_in = e;
  endtask

  // Reference model state: one pair in the stage, one pair offered by EXE.
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;
  req_t        exp_q[$];
  bit          have_pair, offer_v;
  logic        o_v[2], o_re[2], o_we[2], o_e[2];
  logic [1:0]  o_sz[2];
  logic [31:0] o_a[2], o_w[2];
  logic        e_ale[2], e_sent[2];
  logic [4:0]  e_code[2];
  logic [31:0] e_bad[2];

  task automatic gen_offer();
    for (int k = 0; k < 2; k++) begin
      int kind;
      kind    = $urandom_range(0, 2);
      o_v[k]  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      o_re[k] = (kind == 1);
      o_we[k] = (kind == 2);
      o_sz[k] = 2'($urandom_range(0, 2));
      o_a[k]  = $urandom;
      if ($urandom_range(0, 2) != 0) o_a[k] = o_a[k] - (o_a[k] % (32'd1 << o_sz[k]));
      o_w[k]  = $urandom;
      o_e[k]  = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic model_latch();
    bit blocked;
    req_t r;
    blocked = 0;
    for (int k = 0; k < 2; k++) begin
      bit mem, mis;
      mem       = o_re[k] || o_we[k];
      mis       = (o_a[k] % (32'd1 << o_sz[k])) != 0;
      e_ale[k]  = o_v[k] && mem && mis;
      e_code[k] = e_ale[k] ? (o_we[k] ? 5'd5 : 5'd4) : 5'd0;
      e_bad[k]  = o_a[k];
      e_sent[k] = 1'b0;
      if (o_v[k] && mem && !o_e[k] && !e_ale[k] && !blocked) begin
        r.wr   = o_we[k];
        r.size = o_sz[k];
        r.addr = o_a[k];
        if (!o_we[k])          begin r.wstrb = 4'd0;                        r.wdata = o_w[k]; end
        else if (o_sz[k] == 0) begin r.wstrb = 4'(4'd1 << (o_a[k] % 4));   r.wdata = {24'd0, o_w[k][7:0]} * 32'h01010101; end
        else if (o_sz[k] == 1) begin r.wstrb = 4'(4'd3 << (o_a[k] % 4));   r.wdata = {16'd0, o_w[k][15:0]} * 32'h00010001; end
        else                   begin r.wstrb = 4'hF;                        r.wdata = o_w[k]; end
        exp_q.push_back(r);
        e_sent[k] = 1'b1;
      end
      if (o_v[k] && (o_e[k] || e_ale[k])) blocked = 1;
    end
  endtask

  initial begin
    reset = 1'b1; clear_all = 1'b0; es_to_pms_valid = 1'b0; data_sram_addr_ok = 1'b0; ms_allowin = 1'b1;
    set1(0, 0, 0, 2'd0, 32'd0, 32'd0, 0); set2(0, 0, 0, 2'd0, 32'd0, 32'd0, 0);
    tick(); tick();
    #2;
    check("rst_req", data_sram_req, 1'b0);
    check("rst_ptm", pms_to_ms_valid, 1'b0);
    check("rst_ale", {inst1_ale, inst2_ale, inst1_req_sent, inst2_req_sent}, 4'b0000);
    check("rst_code", {inst1_exccode, inst2_exccode}, 10'd0);
    tick();
    reset = 1'b0;

    // ALU pair: one-cycle latency, no request
    set1(1, 0, 0, 2'd2, 32'h100, 32'd0, 0); set2(1, 0, 0, 2'd2, 32'h104, 32'd0, 0);
    es_to_pms_valid = 1'b1;
    #2 check("alu_allowin", pms_allowin, 1'b1);
    tick(); es_to_pms_valid = 1'b0;
    #2 check("alu_ptm", pms_to_ms_valid, 1'b1);
    check("alu_req", data_sram_req, 1'b0);
    check("alu_sent", {inst1_req_sent, inst2_req_sent}, 2'b00);
    tick();
    #2 check("alu_ptm_gone", pms_to_ms_valid, 1'b0);
    tick();

    // sw then lb, addr_ok always high
    set1(1, 0, 1, 2'd2, 32'h10000004, 32'hAABBCCDD, 0); set2(1, 1, 0, 2'd0, 32'h10000003, 32'h55, 0);
    es_to_pms_valid = 1'b1; data_sram_addr_ok = 1'b1;
    tick(); es_to_pms_valid = 1'b0;
    #2 check("sw_req", {data_sram_req, data_sram_wr, data_sram_wstrb}, 6'b11_1111);
    check("sw_addr", data_sram_addr, 32'h10000004);
    check("sw_wdata", data_sram_wdata, 32'hAABBCCDD);
    tick();
    #2 check("lb_req", {data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_size}, 8'b10_0000_00);
    check("lb_addr", data_sram_addr, 32'h10000003);
    tick();
    #2 check("pair_ptm", {pms_to_ms_valid, data_sram_req}, 2'b10);
    check("pair_sent", {inst1_req_sent, inst2_req_sent}, 2'b11);
    tick();

    // misaligned sh blocks both slots
    set1(1, 0, 1, 2'd1, 32'h2001, 32'd0, 0); set2(1, 1, 0, 2'd2, 32'h4000, 32'd0, 0);
    es_to_pms_valid = 1'b1;
    tick(); es_to_pms_valid = 1'b0;
    #2 check("ale_req", data_sram_req, 1'b0);
    check("ale_flags", {inst1_ale, inst2_ale, pms_to_ms_valid}, 3'b101);
    check("ale_code", inst1_exccode, 5'h05);
    check("ale_bad", inst1_badvaddr, 32'h2001);
    check("ale_sent", {inst1_req_sent, inst2_req_sent}, 2'b00);
    tick();

    // sb with addr_ok stalled three cycles
    set1(1, 0, 1, 2'd0, 32'h3002, 32'h12, 0); set2(0, 0, 0, 2'd0, 32'd0, 32'd0, 0);
    es_to_pms_valid = 1'b1; data_sram_addr_ok = 1'b0;
    tick(); es_to_pms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 check("sb_stall", {data_sram_req, data_sram_wstrb, data_sram_wdata, data_sram_addr},
                           {1'b1, 4'b0100, 32'h12121212, 32'h3002});
      tick();
    end
    data_sram_addr_ok = 1'b1;
    #2 check("sb_accept", {data_sram_req, data_sram_wstrb, pms_to_ms_valid}, 6'b1_0100_0);
`ifdef PMS_STALL_CNT_EN
    check("sb_cnt", pms_stall_cnt, 32'd3);
`endif
    tick(); data_sram_addr_ok = 1'b0;
    #2 check("sb_done", {pms_to_ms_valid, inst1_req_sent, inst2_req_sent}, 3'b110);
    tick();

    // flush during pending REQ1 drains the request
    set1(1, 1, 0, 2'd2, 32'h5000, 32'd0, 0);
    es_to_pms_valid = 1'b1;
    tick(); es_to_pms_valid = 1'b0; clear_all = 1'b1;
    #2 check("fl_req", data_sram_req, 1'b1);
    tick(); clear_all = 1'b0;
    #2 check("fl_drain", {data_sram_req, pms_allowin, pms_to_ms_valid}, 3'b100);
    check("fl_addr", data_sram_addr, 32'h5000);
    tick(); data_sram_addr_ok = 1'b1;
    #2 check("fl_drain_ok", {data_sram_req, pms_allowin, pms_to_ms_valid}, 3'b100);
    tick(); data_sram_addr_ok = 1'b0;
    #2 check("fl_idle", {data_sram_req, pms_allowin, pms_to_ms_valid}, 3'b010);
`ifdef PMS_STALL_CNT_EN
    check("fl_cnt", pms_stall_cnt, 32'd5);
`endif
    tick();

    // flush wins over a simultaneous latch
    set1(1, 0, 0, 2'd2, 32'h0, 32'd0, 0);
    es_to_pms_valid = 1'b1; clear_all = 1'b1;
    tick(); es_to_pms_valid = 1'b0; clear_all = 1'b0;
    #2 check("fl_nolatch", {pms_to_ms_valid, pms_allowin}, 2'b01);
    tick();

    // reset in the middle of REQ2
    set1(1, 1, 0, 2'd2, 32'h6000, 32'd0, 0); set2(1, 1, 0, 2'd2, 32'h6004, 32'd0, 0);
    es_to_pms_valid = 1'b1; data_sram_addr_ok = 1'b1;
    tick(); es_to_pms_valid = 1'b0;
    #2 check("rs_req1", data_sram_addr, 32'h6000);
    tick(); data_sram_addr_ok = 1'b0; reset = 1'b1;
    #2 check("rs_req2", {data_sram_req, data_sram_addr}, {1'b1, 32'h6004});
    tick(); reset = 1'b0;
    #2 check("rs_after", {data_sram_req, pms_to_ms_valid, pms_allowin, inst1_req_sent}, 4'b0010);
`ifdef PMS_STALL_CNT_EN
    check("rs_cnt", pms_stall_cnt, 32'd0);
`endif
    tick();

    // randomized traffic against the transaction model
    have_pair = 0; offer_v = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit done;
      if (!offer_v && $urandom_range(0, 2) != 0) begin
        gen_offer();
        offer_v = 1;
      end
      es_to_pms_valid = offer_v;
      set1(o_v[0], o_re[0], o_we[0], o_sz[0], o_a[0], o_w[0], o_e[0]);
      set2(o_v[1], o_re[1], o_we[1], o_sz[1], o_a[1], o_w[1], o_e[1]);
      data_sram_addr_ok = ($urandom_range(0, 2) != 0);
      ms_allowin        = ($urandom_range(0, 3) != 0);
      #2;
      done = have_pair && (exp_q.size() == 0);
      check("rnd_allowin", pms_allowin, !have_pair || (done && ms_allowin));
      check("rnd_req", data_sram_req, have_pair && (exp_q.size() != 0));
      check("rnd_ptm", pms_to_ms_valid, done);
      if (data_sram_req && exp_q.size() != 0) begin
        check("rnd_fields", {data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb},
                            {exp_q[0].wr, exp_q[0].size, exp_q[0].addr, exp_q[0].wstrb});
        if (exp_q[0].wr) check("rnd_wdata", data_sram_wdata, exp_q[0].wdata);
        if (data_sram_addr_ok) void'(exp_q.pop_front());
      end
      if (done) begin
        check("rnd_sent", {inst1_req_sent, inst2_req_sent}, {e_sent[0], e_sent[1]});
        check("rnd_exc", {inst1_ale, inst1_exccode, inst2_ale, inst2_exccode},
                         {e_ale[0], e_code[0], e_ale[1], e_code[1]});
        if (e_ale[0]) check("rnd_bad1", inst1_badvaddr, e_bad[0]);
        if (e_ale[1]) check("rnd_bad2", inst2_badvaddr, e_bad[1]);
        if (ms_allowin) have_pair = 0;
      end
      if (offer_v && pms_allowin) begin
        model_latch();
        have_pair = 1;
        offer_v   = 0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
